// File: rtl/triangle_host.sv
// triangle_host: host-side initiator/collector for the triangle point generator.
// Takes one triangle command and sorts its vertices by y (stable). It sends them
// on nt/xi/yi, then records every reported inside point into an 8x8 bitmap.
// A distinct-pixel counter tracks the bitmap, and done pulses when the triangle ends.
module triangle_host #(
    parameter logic [6:0] TIMEOUT        = 7'd127,
    parameter bit         CLEAR_ON_START = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [17:0] cmd_vtx,
    output logic        nt,
    output logic [2:0]  xi,
    output logic [2:0]  yi,
    input  logic        busy,
    input  logic        po,
    input  logic [2:0]  xo,
    input  logic [2:0]  yo,
    output logic        done,
    output logic        err,
    output logic [6:0]  pix_count,
    input  logic [2:0]  rd_row,
    output logic [7:0]  rd_data
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SORT      = 3'd1,
        SEND0     = 3'd2,
        SEND1     = 3'd3,
        SEND2     = 3'd4,
        WAIT_BUSY = 3'd5,
        COLLECT   = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] vtx_q, vtx_d;
    logic        nt_q, nt_d;
    logic [2:0]  xi_q, xi_d, yi_q, yi_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] bitmap_q, bitmap_d;
    logic [6:0]  pix_q, pix_d;

    logic [11:0] p01_s, p12_s, p01b_s;
    logic [5:0]  s0_s, s1_s, s2_s;
    logic [6:0]  cnt_inc_s;
    logic [5:0]  pt_idx_s;
    logic        capture_s;

    // Compare-and-swap on two {x,y} vertices: swap only when the first y is
    // strictly greater, so equal-y vertices keep their command order.
    function automatic logic [11:0] cas(input logic [11:0] p);
        return (p[8:6] > p[2:0]) ? {p[5:0], p[11:6]} : p;
    endfunction

    // Three-element bubble network over the latched command (v0,v1,v2 order).
    assign p01_s  = cas({vtx_q[17:12], vtx_q[11:6]});
    assign p12_s  = cas({p01_s[5:0], vtx_q[5:0]});
    assign p01b_s = cas({p01_s[11:6], p12_s[11:6]});
    assign s0_s   = p01b_s[11:6];
    assign s1_s   = p01b_s[5:0];
    assign s2_s   = p12_s[5:0];

    assign cnt_inc_s = cnt_q + 7'd1;
    assign pt_idx_s  = {yo, xo};
    // Points are accepted from the moment we start waiting for busy until done.
    assign capture_s = po && ((state_q == WAIT_BUSY) || (state_q == COLLECT) || (state_q == DONE));

    // Next-state, bitmap capture and output-register next values.
    always_comb begin
        state_d  = state_q;
        vtx_d    = vtx_q;
        xi_d     = xi_q;
        yi_d     = yi_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        bitmap_d = bitmap_q;
        pix_d    = pix_q;
        nt_d     = 1'b0;
        done_d   = 1'b0;

        if (capture_s && !bitmap_q[pt_idx_s]) begin
            bitmap_d[pt_idx_s] = 1'b1;
            if (pix_q < 7'd64) begin
                pix_d = pix_q + 7'd1;
            end else begin
                pix_d = pix_q;
            end
        end else begin
            bitmap_d = bitmap_q;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    vtx_d   = cmd_vtx;
                    err_d   = 1'b0;
                    state_d = SORT;
                    if (CLEAR_ON_START) begin
                        bitmap_d = 64'd0;
                        pix_d    = 7'd0;
                    end else begin
                        bitmap_d = bitmap_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SORT: begin
                state_d      = SEND0;
                {xi_d, yi_d} = s0_s;
            end
            SEND0: begin
                state_d      = SEND1;
                {xi_d, yi_d} = s1_s;
            end
            SEND1: begin
                state_d      = SEND2;
                {xi_d, yi_d} = s2_s;
            end
            SEND2: begin
                state_d = WAIT_BUSY;
                cnt_d   = 7'd0;
            end
            WAIT_BUSY: begin
                if (cnt_inc_s == TIMEOUT) begin
                    err_d   = 1'b1;
                    cnt_d   = TIMEOUT;
                    state_d = DONE;
                end else if (busy) begin
                    cnt_d   = cnt_inc_s;
                    state_d = COLLECT;
                end else begin
                    cnt_d   = cnt_inc_s;
                end
            end
            COLLECT: begin
                if (!busy) begin
                    state_d = DONE;
                end else if (cnt_inc_s == TIMEOUT) begin
                    err_d   = 1'b1;
                    cnt_d   = TIMEOUT;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        nt_d   = (state_d == SEND0);
        done_d = (state_d == DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            vtx_q    <= 18'd0;
            nt_q     <= 1'b0;
            xi_q     <= 3'd0;
            yi_q     <= 3'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 7'd0;
            bitmap_q <= 64'd0;
            pix_q    <= 7'd0;
        end else begin
            state_q  <= state_d;
            vtx_q    <= vtx_d;
            nt_q     <= nt_d;
            xi_q     <= xi_d;
            yi_q     <= yi_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            bitmap_q <= bitmap_d;
            pix_q    <= pix_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign nt        = nt_q;
    assign xi        = xi_q;
    assign yi        = yi_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pix_count = pix_q;
    assign rd_data   = bitmap_q[{rd_row, 3'b000} +: 8];

endmodule

// File: tb/tb_triangle_host.sv
// Self-checking bench for triangle_host: a clearing instance and an accumulating instance
// share all inputs. Expected vertex order is queued at command time and checked on nt.
module tb_triangle_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [17:0] cmd_vtx;
    logic        busy, po;
    logic [2:0]  xo, yo, rd_row;

    logic        cmd_ready, nt, done, err;
    logic [2:0]  xi, yi;
    logic [6:0]  pix_count;
    logic [7:0]  rd_data;

    logic        a_cmd_ready, a_nt, a_done, a_err;
    logic [2:0]  a_xi, a_yi;
    logic [6:0]  a_pix_count;
    logic [7:0]  a_rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] exp_q [$];
    logic [5:0] e_m;
    int         ser_left = 0;

    typedef struct {
        logic [17:0]     vtx;
        logic [17:0]     exp_s;
        int              npts;
        logic [3:0][5:0] pts;
        logic [6:0]      exp_pix;
        logic [2:0]      row;
        logic [7:0]      exp_row;
        logic [6:0]      exp_acc;
    } vec_t;

    vec_t tbl [7];

    triangle_host #(.TIMEOUT(7'd127), .CLEAR_ON_START(1'b1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_vtx(cmd_vtx), .nt(nt), .xi(xi), .yi(yi), .busy(busy), .po(po),
        .xo(xo), .yo(yo), .done(done), .err(err), .pix_count(pix_count),
        .rd_row(rd_row), .rd_data(rd_data)
    );

    triangle_host #(.TIMEOUT(7'd127), .CLEAR_ON_START(1'b0)) dut_acc (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_vtx(cmd_vtx), .nt(a_nt), .xi(a_xi), .yi(a_yi), .busy(busy), .po(po),
        .xo(xo), .yo(yo), .done(a_done), .err(a_err), .pix_count(a_pix_count),
        .rd_row(rd_row), .rd_data(a_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pt(input int x, input int y);
        logic [2:0] xx, yy;
        xx = x[2:0];
        yy = y[2:0];
        return {xx, yy};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Scoreboard: on nt the three queued vertices must appear on consecutive cycles.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            ser_left = 0;
        end else if (nt) begin
            check("nt_single", ser_left, 0);
            check("queue_depth_at_nt", exp_q.size(), 3);
            if (exp_q.size() > 0) begin
                e_m = exp_q.pop_front();
                check("vtx0", {xi, yi}, e_m);
            end
            ser_left = 2;
        end else if (ser_left > 0) begin
            if (exp_q.size() > 0) begin
                e_m = exp_q.pop_front();
                check((ser_left == 2) ? "vtx1" : "vtx2", {xi, yi}, e_m);
            end
            ser_left--;
        end
    end

    task automatic send_cmd(input logic [17:0] vtx, input logic [17:0] exp_s);
        int k;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_vtx   = vtx;
        exp_q.push_back(exp_s[17:12]);
        exp_q.push_back(exp_s[11:6]);
        exp_q.push_back(exp_s[5:0]);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_ready_after_accept", cmd_ready, 0);
        check("err_cleared_on_accept", err, 0);
    endtask

    task automatic raster(input int npts, input logic [3:0][5:0] pts);
        busy = 1'b1;
        if (npts == 0) begin
            po = 1'b0;
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i < npts; i++) begin
                po       = 1'b1;
                {xo, yo} = pts[i];
                @(posedge clk); #1;
            end
        end
        busy = 1'b0;
        po   = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (k < limit) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        check("done_seen", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("cmd_ready_after_done", cmd_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        send_cmd(v.vtx, v.exp_s);
        repeat (4) @(posedge clk);
        #1;
        raster(v.npts, v.pts);
        wait_done(20);
        check({tag, "_pix"}, pix_count, v.exp_pix);
        check({tag, "_acc_pix"}, a_pix_count, v.exp_acc);
        check({tag, "_xy_hold"}, {xi, yi}, v.exp_s[5:0]);
        rd_row = v.row;
        #1;
        check({tag, "_row"}, rd_data, v.exp_row);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        tbl[0] = '{{3'd1,3'd5,3'd1,3'd0,3'd6,3'd2}, {pt(1,0),pt(6,2),pt(1,5)}, 3,
                   {6'd0,pt(2,1),pt(1,1),pt(1,0)}, 7'd3, 3'd1, 8'b0000_0110, 7'd3};
        tbl[1] = '{{3'd0,3'd0,3'd7,3'd7,3'd3,3'd3}, {pt(0,0),pt(3,3),pt(7,7)}, 2,
                   {6'd0,6'd0,pt(3,3),pt(3,3)}, 7'd1, 3'd3, 8'b0000_1000, 7'd4};
        tbl[2] = '{{3'd5,3'd2,3'd1,3'd2,3'd4,3'd2}, {pt(5,2),pt(1,2),pt(4,2)}, 4,
                   {pt(0,0),pt(7,0),pt(7,7),pt(0,7)}, 7'd4, 3'd7, 8'b1000_0001, 7'd8};
        tbl[3] = '{{3'd2,3'd6,3'd3,3'd4,3'd4,3'd1}, {pt(4,1),pt(3,4),pt(2,6)}, 0,
                   {6'd0,6'd0,6'd0,6'd0}, 7'd0, 3'd0, 8'b0000_0000, 7'd8};
        tbl[4] = '{{3'd6,3'd3,3'd2,3'd1,3'd0,3'd3}, {pt(2,1),pt(6,3),pt(0,3)}, 3,
                   {6'd0,pt(4,5),pt(5,5),pt(6,5)}, 7'd3, 3'd5, 8'b0111_0000, 7'd11};
        tbl[5] = '{{3'd1,3'd5,3'd1,3'd0,3'd6,3'd2}, {pt(1,0),pt(6,2),pt(1,5)}, 3,
                   {6'd0,pt(2,0),pt(1,0),pt(0,0)}, 7'd3, 3'd0, 8'b0000_0111, 7'd3};
        tbl[6] = '{{3'd0,3'd0,3'd7,3'd7,3'd3,3'd3}, {pt(0,0),pt(3,3),pt(7,7)}, 2,
                   {6'd0,6'd0,pt(6,6),pt(5,6)}, 7'd2, 3'd6, 8'b0110_0000, 7'd5};

        reset = 1'b0; cmd_valid = 1'b0; cmd_vtx = 18'd0;
        busy = 1'b0; po = 1'b0; xo = 3'd0; yo = 3'd0; rd_row = 3'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_nt", nt, 0);
        check("rst_xy", {xi, yi}, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_pix", pix_count, 0);
        for (int r = 0; r < 8; r++) begin
            rd_row = r[2:0];
            #1;
            check("rst_row", rd_data, 0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Table-driven triangles
        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Timeout: busy never rises
        send_cmd({3'd3,3'd1,3'd0,3'd2,3'd5,3'd0}, {pt(5,0),pt(3,1),pt(0,2)});
        k = 1;
        while (k < 300) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        check("timeout_done", done, 1);
        check("timeout_err", err, 1);
        check("timeout_latency_window", (k >= 128 && k <= 134), 1);
        @(negedge clk);
        check("timeout_done_one_cycle", done, 0);
        check("timeout_cmd_ready", cmd_ready, 1);
        check("timeout_err_sticky", err, 1);
        check("timeout_pix", pix_count, 0);
        check("timeout_acc_pix", a_pix_count, 11);

        // Reset during SEND0: nt must drop without a clock edge
        send_cmd(tbl[0].vtx, tbl[0].exp_s);
        @(posedge clk); #1;
        check("nt_before_reset", nt, 1);
        reset = 1'b0;
        #1;
        check("nt_async_drop", nt, 0);
        check("reset_send_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b1;

        // Reset during COLLECT after two points
        send_cmd(tbl[1].vtx, tbl[1].exp_s);
        repeat (4) @(posedge clk);
        #1;
        busy = 1'b1; po = 1'b1; {xo, yo} = pt(1, 2);
        @(posedge clk); #1;
        {xo, yo} = pt(4, 4);
        @(posedge clk); #1;
        check("midop_pix_before", pix_count, 2);
        reset = 1'b0;
        busy = 1'b0; po = 1'b0;
        #1;
        check("midop_pix", pix_count, 0);
        check("midop_acc_pix", a_pix_count, 0);
        check("midop_ready", cmd_ready, 1);
        check("midop_done", done, 0);
        for (int r = 0; r < 8; r++) begin
            rd_row = r[2:0];
            #1;
            check("midop_row", rd_data, 0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Accumulation across two triangles with disjoint points
        run_vec(tbl[5], "accA");
        run_vec(tbl[6], "accB");
        rd_row = 3'd0;
        #1;
        check("accB_acc_row0", a_rd_data, 8'b0000_0111);

        repeat (3) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
